// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the handler vector used by the exception PC select.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IM_HI     = 15;
  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w = '0;
    w[SR_IM_HI:SR_IM_LO] = im;
    w[SR_EXL]            = exl;
    w[SR_IE]             = ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD]                   = bd;
    w[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO]  = code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage <-> CP0 signal bundle: mfc0/mtc0 access, exception inputs,
// interrupt lines and the request/EPC results.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic        EXLClr;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic        ExcReq;
  logic [31:0] EPC;
  logic [31:0] CP0O;

  modport master (
    output A1, A2, DIn, We, EXLClr, PC, BD, ExcCode_M, HWInt,
    input  IntReq, ExcReq, EPC, CP0O
  );

  modport slave (
    input  A1, A2, DIn, We, EXLClr, PC, BD, ExcCode_M, HWInt,
    output IntReq, ExcReq, EPC, CP0O
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: takes interrupts/exceptions from M, records SR/Cause/EPC,
// and serves mfc0/mtc0 and the eret target.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4D49_5053
) (
  input  logic   clk,
  input  logic   rst_n,
  cp0_if.slave   bus
);

  logic [5:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic [5:0]  ip_reg;
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;

  logic        int_req;
  logic        exc_req;
  logic        take_req;
  logic [31:0] pc_victim;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Interrupts win over a simultaneous exception; EXL masks both.
  assign int_req  = (|(bus.HWInt & im_reg)) & ie_reg & ~exl_reg;
  assign exc_req  = (bus.ExcCode_M != EXC_INT) & ~exl_reg & ~int_req;
  assign take_req = int_req | exc_req;

  assign pc_victim = bus.BD ? (bus.PC - 32'd4) : bus.PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_reg       <= '0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else begin
      ip_reg <= bus.HWInt;
      if (take_req) begin
        exl_reg      <= 1'b1;
        bd_reg       <= bus.BD;
        exc_code_reg <= int_req ? EXC_INT : bus.ExcCode_M;
        epc_reg      <= {pc_victim[31:2], 2'b00};
      end else begin
        if (bus.We && bus.A2 == REG_SR) begin
          im_reg  <= bus.DIn[SR_IM_HI:SR_IM_LO];
          exl_reg <= bus.DIn[SR_EXL];
          ie_reg  <= bus.DIn[SR_IE];
        end
        if (bus.We && bus.A2 == REG_EPC) begin
          epc_reg <= bus.DIn;
        end
        // eret overrides a same-cycle SR write so EXL always ends cleared.
        if (bus.EXLClr) begin
          exl_reg <= 1'b0;
        end
      end
    end
  end

  assign sr_word    = pack_sr(im_reg, exl_reg, ie_reg);
  assign cause_word = pack_cause(bd_reg, ip_reg, exc_code_reg);

  always_comb begin
    bus.CP0O = '0;
    case (bus.A1)
      REG_SR:    bus.CP0O = sr_word;
      REG_CAUSE: bus.CP0O = cause_word;
      REG_EPC:   bus.CP0O = epc_reg;
      REG_PRID:  bus.CP0O = PRID;
      default:   bus.CP0O = '0;
    endcase
  end

  assign bus.IntReq = int_req;
  assign bus.ExcReq = exc_req;
  assign bus.EPC    = epc_reg;

endmodule

// File: doc/cp0.md
# cp0

System-control coprocessor 0 for the exception/interrupt pipeline. It takes the merged M-stage exception code, the M-stage PC and delay-slot flag, and six hardware interrupt lines, and decides whether to take an exception or interrupt. When one is taken it records Cause and EPC, sets SR.EXL, and raises `IntReq`/`ExcReq`; those lines drive the handler-vector PC select and freeze the multiply/divide unit. It also serves `mfc0`/`mtc0` accesses from M and supplies the `eret` return PC.

## Interface
- `PRID`, default 32'h4D49_5053, fixed contents of PRId (reg 15).
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `A1` input 5: `mfc0` read register number.
- `A2` input 5: `mtc0` write register number.
- `DIn` input 32: `mtc0` write data (M-stage rt value).
- `We` input 1: `mtc0` write enable from M.
- `EXLClr` input 1: `eret` in M; clears SR.EXL.
- `PC` input 32: PC of the M-stage instruction.
- `BD` input 1: M-stage instruction is in a branch delay slot.
- `ExcCode_M` input 5: merged M-stage exception code; 0 means no exception.
- `HWInt` input 6: level-sensitive hardware interrupt lines [7:2].
- `IntReq` output 1: interrupt taken this cycle.
- `ExcReq` output 1: synchronous exception taken this cycle.
- `EPC` output 32: current EPC register value (eret target).
- `CP0O` output 32: `mfc0` read data.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC (14): full 32 bits.
  - PRId (15): `PRID`.
- `IntReq` = |(HWInt & SR.IM) & SR.IE & ~SR.EXL (combinational).
- `ExcReq` = (ExcCode_M != 0) & ~SR.EXL & ~IntReq. An interrupt wins over a simultaneous exception.
- On `IntReq` or `ExcReq` at the clock edge:
  - SR.EXL <= 1.
  - Cause.BD <= BD.
  - Cause.ExcCode <= (IntReq ? 0 : ExcCode_M).
  - EPC <= {(BD ? PC-4 : PC)[31:2], 2'b00}. Subtraction is 32-bit and wraps modulo 2^32.
- Cause.IP <= HWInt every cycle, independent of EXL and of any write.
- `mtc0`:
  - When `We` is high and neither request is active: A2=12 writes only IM, EXL and IE; A2=14 writes all of EPC.
  - Writes to 13, 15 and unmapped numbers are ignored.
  - A request in the same cycle suppresses the write.
- `eret`: `EXLClr` high clears SR.EXL. A request cannot coincide with it because EXL=1 blocks requests. If `We` to SR and `EXLClr` fall in the same cycle, EXL ends at 0.
- `CP0O` is combinational from `A1` and the register state: 12/13/14/15 return the register, everything else returns 0. There is no write-through bypass; the hazard unit stalls `mfc0` or `eret` behind an in-flight `mtc0`.

## Timing
- Reset (async, `rst_n`=0):
  - SR = 0 (IM=0, EXL=0, IE=0).
  - Cause = 0.
  - EPC = 0.
  - Outputs: `IntReq`=0, `ExcReq`=0, `EPC`=0, `CP0O`=0 for any A1 except 15, which reads `PRID`.
- Reset asserted mid-operation clears all state immediately, regardless of pending requests.
- Request latency:
  - `IntReq`/`ExcReq` are combinational in the same cycle as the cause. The pipeline redirects the PC to 0x0000_4180 and flushes on the next edge.
  - SR, Cause and EPC update on that same edge.
  - Requests are low from the following cycle because EXL=1.
- `HWInt` asserted while EXL=1 stays pending in IP. It raises `IntReq` in the first cycle after EXL clears, if IE and IM allow.
- `mtc0` result is visible on `CP0O`/`EPC` one cycle after the write edge.

## Structure
- Shared package `cp0_pkg`:
  - register numbers SR=12, CAUSE=13, EPC=14, PRID=15;
  - bit positions for IM, EXL, IE, BD, IP, ExcCode;
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - handler vector 32'h0000_4180, also used by the exception PC select.
- Single flat module; no sub-module.

## Test plan
- Reset, then read A1=12, 13, 14, 15 -> 0, 0, 0, `PRID`. Both requests are 0.
- `mtc0` SR=32'h0000_FC01, then HWInt=6'b000100 -> `IntReq`=1 that cycle; next cycle Cause=32'h0000_1000, EXL=1, EPC=PC & ~3, `IntReq`=0.
- ExcCode_M=12 (Ov), PC=32'h0000_3010, BD=1, EXL=0 -> `ExcReq`=1; then EPC=32'h0000_300C, Cause=32'h8000_0030.
- ExcCode_M=4 and an enabled interrupt in the same cycle -> `IntReq`=1, `ExcReq`=0, Cause.ExcCode=0.
- While EXL=1: `ExcCode_M`=10 -> no request and EPC unchanged; then `EXLClr` -> EXL=0, and a still-pending HWInt raises `IntReq` the next cycle.
- `We`=1 A2=14 DIn=32'h1234_5678 coinciding with an exception -> EPC holds the exception PC, not the write data. Pulse `rst_n` low mid-sequence -> all registers 0 asynchronously.
